// File: rtl/fa_selftest_driver.sv
// Built-in self-test driver/checker for a 1-bit full adder: walks all eight {a,b,cin} vectors.
// Optional per-vector failure mask is built only when FA_SELFTEST_MASK_EN is defined.
module fa_selftest_driver #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       cin,
    input  logic       sum,
    input  logic       carry,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] first_fail_vec,
    output logic       first_fail_valid,
    output logic [7:0] fail_mask
);

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] vec_q, vec_d;
    logic [3:0] cnt_q, cnt_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic       cin_q, cin_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [3:0] err_count_q, err_count_d;
    logic [2:0] ffv_q, ffv_d;
    logic       ffvalid_q, ffvalid_d;
    logic       exp_sum_s;
    logic       exp_carry_s;
    logic       mismatch_s;
    logic       accept_s;

    assign accept_s    = (state_q == ST_IDLE) && start;
    assign exp_sum_s   = a_q ^ b_q ^ cin_q;
    assign exp_carry_s = (a_q & b_q) | (a_q & cin_q) | (b_q & cin_q);
    assign mismatch_s  = (sum != exp_sum_s) || (carry != exp_carry_s);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                // cnt counts SETTLE..1, so this state lasts exactly SETTLE cycles
                if (cnt_q <= 4'd1) begin
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_CHECK: begin
                if (vec_q == 3'd7) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Vector/counter sequencing and result accumulation
    always_comb begin
        vec_d       = vec_q;
        cnt_d       = cnt_q;
        err_count_d = err_count_q;
        ffv_d       = ffv_q;
        ffvalid_d   = ffvalid_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    vec_d       = 3'd0;
                    cnt_d       = SETTLE_CNT;
                    err_count_d = 4'd0;
                    ffv_d       = 3'd0;
                    ffvalid_d   = 1'b0;
                end else begin
                    vec_d = vec_q;
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_q - 4'd1;
            end
            ST_CHECK: begin
                if (mismatch_s) begin
                    err_count_d = err_count_q + 4'd1;
                    if (!ffvalid_q) begin
                        ffv_d     = vec_q;
                        ffvalid_d = 1'b1;
                    end else begin
                        ffv_d = ffv_q;
                    end
                end else begin
                    err_count_d = err_count_q;
                end
                if (vec_q != 3'd7) begin
                    vec_d = vec_q + 3'd1;
                    cnt_d = SETTLE_CNT;
                end else begin
                    vec_d = vec_q;
                end
            end
            ST_DONE: begin
                cnt_d = cnt_q;
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // Outputs are computed from the next state so they are registered yet aligned to it
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        a_d    = 1'b0;
        b_d    = 1'b0;
        cin_d  = 1'b0;
        case (state_d)
            ST_SETTLE, ST_CHECK: begin
                busy_d = 1'b1;
                a_d    = vec_d[2];
                b_d    = vec_d[1];
                cin_d  = vec_d[0];
            end
            ST_DONE: begin
                done_d = 1'b1;
            end
            ST_IDLE: begin
                busy_d = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
        if (accept_s) begin
            pass_d = 1'b0;
        end else if (state_d == ST_DONE) begin
            pass_d = (err_count_d == 4'd0);
        end else begin
            pass_d = pass_q;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q       <= 3'd0;
            cnt_q       <= 4'd0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            cin_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= 4'd0;
            ffv_q       <= 3'd0;
            ffvalid_q   <= 1'b0;
        end else begin
            vec_q       <= vec_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cin_q       <= cin_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_count_q <= err_count_d;
            ffv_q       <= ffv_d;
            ffvalid_q   <= ffvalid_d;
        end
    end

`ifdef FA_SELFTEST_MASK_EN
    logic [7:0] mask_q, mask_d;

    // Per-vector failure mask: cleared on start, held after the run
    always_comb begin
        mask_d = mask_q;
        if (accept_s) begin
            mask_d = 8'h00;
        end else if ((state_q == ST_CHECK) && mismatch_s) begin
            mask_d[vec_q] = 1'b1;
        end else begin
            mask_d = mask_q;
        end
    end

    // Mask register
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= 8'h00;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign fail_mask = mask_q;
`else
    assign fail_mask = 8'h00;
`endif

    assign a                = a_q;
    assign b                = b_q;
    assign cin              = cin_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_count_q;
    assign first_fail_vec   = ffv_q;
    assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_fa_selftest_driver.sv
// Scoreboard bench for fa_selftest_driver: two instances (SETTLE=1 and SETTLE=3) each test a
// behavioural adder with injectable per-vector faults; FA_SELFTEST_MASK_EN selects mask expectations.
module tb_fa_selftest_driver;

    localparam int S0 = 1;
    localparam int S1 = 3;

    typedef struct packed {
        logic [3:0] ec;
        logic [2:0] fv;
        logic       fvalid;
        logic       pass;
        logic [7:0] mask;
    } res_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] sum_flip = 8'h00;
    logic [7:0] carry_flip = 8'h00;

    logic [1:0] a_o, b_o, cin_o, sum_i, carry_i, busy_o, done_o, pass_o, ffvalid_o;
    logic [3:0] err_o [2];
    logic [2:0] ffv_o [2];
    logic [7:0] mask_o [2];

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc [2] = '{0, 0};
    res_t held [2] = '{'0, '0};
    res_t sbq0 [$];
    res_t sbq1 [$];

    always #5 clk = ~clk;

    // Adder under test: correct full adder with optional per-vector output inversions
    for (genvar k = 0; k < 2; k++) begin : g_adder
        assign sum_i[k]   = (a_o[k] ^ b_o[k] ^ cin_o[k]) ^ sum_flip[{a_o[k], b_o[k], cin_o[k]}];
        assign carry_i[k] = ((32'(a_o[k]) + 32'(b_o[k]) + 32'(cin_o[k])) >= 32'd2)
                            ^ carry_flip[{a_o[k], b_o[k], cin_o[k]}];
    end

    fa_selftest_driver #(.SETTLE(S0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start),
        .a(a_o[0]), .b(b_o[0]), .cin(cin_o[0]), .sum(sum_i[0]), .carry(carry_i[0]),
        .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]), .err_count(err_o[0]),
        .first_fail_vec(ffv_o[0]), .first_fail_valid(ffvalid_o[0]), .fail_mask(mask_o[0])
    );

    fa_selftest_driver #(.SETTLE(S1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start),
        .a(a_o[1]), .b(b_o[1]), .cin(cin_o[1]), .sum(sum_i[1]), .carry(carry_i[1]),
        .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]), .err_count(err_o[1]),
        .first_fail_vec(ffv_o[1]), .first_fail_valid(ffvalid_o[1]), .fail_mask(mask_o[1])
    );

    // Expected run result straight from the fault pattern: a vector fails if any output is flipped
    function automatic res_t expect_run(input logic [7:0] sf, input logic [7:0] cf);
        res_t r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (sf[i] || cf[i]) begin
                r.ec = r.ec + 4'd1;
                if (!r.fvalid) begin
                    r.fvalid = 1'b1;
                    r.fv     = 3'(i);
                end
`ifdef FA_SELFTEST_MASK_EN
                r.mask[i] = 1'b1;
`endif
            end
        end
        r.pass = (r.ec == 4'd0);
        return r;
    endfunction

    function automatic int last_cycle(input int k);
        return 8 * (((k == 0) ? S0 : S1) + 1) + 1;
    endfunction

    task automatic chk(input string name, input int k, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s[inst%0d] at %0t: got %0d expected %0d", name, k, $time, act, exp);
        end
    endtask

    task automatic cmp_res(input int k, input res_t r);
        chk("err_count", k, int'(err_o[k]), int'(r.ec));
        chk("first_fail_vec", k, int'(ffv_o[k]), int'(r.fv));
        chk("first_fail_valid", k, int'(ffvalid_o[k]), int'(r.fvalid));
        chk("pass", k, int'(pass_o[k]), int'(r.pass));
        chk("fail_mask", k, int'(mask_o[k]), int'(r.mask));
    endtask

    // Run-position model: tracks cycles since acceptance and pushes expected results on start
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                cyc[k] <= 0;
                if (k == 0) sbq0.delete(); else sbq1.delete();
            end else if (cyc[k] == 0) begin
                if (start) begin
                    cyc[k] <= 1;
                    if (k == 0) sbq0.push_back(expect_run(sum_flip, carry_flip));
                    else        sbq1.push_back(expect_run(sum_flip, carry_flip));
                end
            end else if (cyc[k] == last_cycle(k)) begin
                cyc[k] <= 0;
            end else begin
                cyc[k] <= cyc[k] + 1;
            end
        end
    end

    // Monitor: per-cycle stimulus/handshake checks, result pop-and-compare on done
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            automatic int   p    = ((k == 0) ? S0 : S1) + 1;
            automatic int   lc   = 8 * p + 1;
            automatic int   c    = cyc[k];
            automatic int   ev   = (c >= 1 && c < lc) ? (c - 1) / p : 0;
            automatic bit   have = 1'b0;
            automatic res_t r    = '0;
            chk("abc", k, int'({a_o[k], b_o[k], cin_o[k]}), ev);
            chk("busy", k, int'(busy_o[k]), int'(c >= 1 && c < lc));
            chk("done", k, int'(done_o[k]), int'(c == lc));
            if (c == lc) begin
                if (k == 0 && sbq0.size() > 0) begin
                    r = sbq0.pop_front();
                    have = 1'b1;
                end else if (k == 1 && sbq1.size() > 0) begin
                    r = sbq1.pop_front();
                    have = 1'b1;
                end
                chk("scoreboard_entry", k, int'(have), 1);
                if (have) begin
                    cmp_res(k, r);
                    held[k] <= r;
                end
            end else if (c == 1) begin
                cmp_res(k, '0);
                held[k] <= '0;
            end else if (c == 0) begin
                if (rst) begin
                    cmp_res(k, '0);
                    held[k] <= '0;
                end else begin
                    cmp_res(k, held[k]);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && !(cyc[0] == 0 && cyc[1] == 0); i++) step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run(input logic [7:0] sf, input logic [7:0] cf);
        wait_idle();
        sum_flip   = sf;
        carry_flip = cf;
        pulse_start();
    endtask

    initial begin
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        repeat (3) step();

        run(8'h00, 8'h00);
        run(8'h00, 8'hE8);
        run(8'hFF, 8'h00);

        // Second start at cycle 5 must be ignored
        run(8'h00, 8'h00);
        repeat (4) step();
        pulse_start();

        // Start in the cycle right after done restarts and clears the results
        run(8'h10, 8'h02);
        for (int i = 0; i < 100 && cyc[0] != last_cycle(0); i++) step();
        step();
        pulse_start();

        // Reset mid-run with a faulty adder: no done afterwards
        run(8'hFF, 8'hE8);
        for (int i = 0; i < 100 && cyc[0] != 6; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (40) step();

        for (int n = 0; n < 10; n++) begin
            run(8'($urandom), 8'($urandom & 32'hFF));
        end

        wait_idle();
        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
